delay_timer_meter: RTL and testbench
====================================

// Module: delay_timer_meter
// PURPOSE
//  Measures the response of a programmable delay timer from outside, at the far end of its trigger/output interface.
//  Watches the trigger line and the active-low timer output; per trigger edge, reports the trigger-to-output
//  delay and the output-low pulse width in clock cycles. Used for self-check and calibration of timer weighted_bits.
// PARAMETERS
//  WEIGHT_BIT_WIDTH  8  width of cycle counters and measurement outputs; counts saturate at 2^W-1
// PORTS
//  clk             input   1  single clock, rising edge
//  rst             input   1  asynchronous, active-high reset
//  trigger_in      input   1  trigger line driven into the timer (asynchronous)
//  delay_out_n     input   1  timer output, active low (asynchronous)
//  busy            output  1  high while a measurement is in progress (state != IDLE)
//  meas_valid      output  1  one-cycle strobe; meas_* outputs valid and held until next strobe
//  meas_delay      output  W  cycles from detected trigger edge to detected output edge
//  meas_width      output  W  cycles delay_out_n stayed low (0 if response was a rising edge)
//  meas_trig_pol   output  1  1 = measurement started by trigger rise, 0 = by trigger fall
//  meas_timeout    output  1  1 = a counter saturated before the expected output edge
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0; trigger sync flops reset 0, delay_out_n sync flops reset 1.
//  Inputs pass through 2-flop synchronizers plus 1 edge-detect flop; equal latency on both, so it cancels in counts.
//  trig_edge = synced trigger rise|fall; out_fall / out_rise = synced delay_out_n edges.
//  Counter: cleared to 0 in cycle of start event, +1 every later cycle, saturates at 2^W-1 (no wrap).
//  FSM states: IDLE, WAIT_RESP, MEAS_WIDTH, REPORT.
//   IDLE: trig_edge -> WAIT_RESP, counter=0, latch polarity. Output edges ignored, including edge at reset exit.
//   WAIT_RESP:
//    - out_fall: meas_delay<=counter, counter=0 -> MEAS_WIDTH
//    - out_rise: meas_delay<=counter, meas_width<=0 -> REPORT
//    - else trig_edge: retrigger; counter=0, relatch polarity, stay
//    - else counter==2^W-1: meas_delay<=max, meas_width<=0, timeout=1 -> REPORT
//    - output edge and trig_edge in same cycle: output edge wins; that trigger edge is dropped.
//   MEAS_WIDTH: trigger edges ignored.
//    - out_rise: meas_width<=counter -> REPORT
//    - counter==2^W-1: meas_width<=max, timeout=1 -> REPORT
//   REPORT (exactly 1 cycle): meas_valid=1.
//    - trig_edge this cycle: start new measurement -> WAIT_RESP, counter=0
//    - else -> IDLE
//  meas_* registers update only when entering REPORT (delay captured earlier, committed together).
//  meas_timeout cleared at each new start. Outputs are stable except at the meas_valid cycle.
//  Async rst mid-measurement: immediate return to reset values; no meas_valid pulse for the aborted measurement.
// TESTING (W=8 unless noted; N = cycles between input edges at the pins)
//  1 trig rise; out_n falls N=3 later; rises 10 after that -> meas_valid once, delay=3, width=10, pol=1, timeout=0.
//  2 trig fall; out_n rises N=5 later, no fall -> delay=5, width=0, pol=0, timeout=0.
//  3 W=4: trig rise, out_n never moves -> valid 15 cycles after start: delay=15, width=0, timeout=1; busy then drops.
//  4 trig rise; second trig edge 4 cycles later; out_n falls 6 after 2nd edge, rises 2 later -> delay=6, width=2.
//  5 out_n fall and trig edge in same synced cycle during WAIT_RESP -> fall taken; trig edge ignored; width measured.
//  6 rst pulse during MEAS_WIDTH -> all outputs 0 at once; no meas_valid; next trigger measures normally.

Source files
------------

// File: rtl/delay_timer_meter.sv
// delay_timer_meter: external response meter for a programmable delay timer.
// Watches the trigger line and the active-low timer output. For each trigger
// edge it reports the trigger-to-output delay and the output-low pulse width,
// both in clock cycles, saturating at 2^W-1.
module delay_timer_meter #(
  parameter int WEIGHT_BIT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trigger_in,
  input  logic                        delay_out_n,
  output logic                        busy,
  output logic                        meas_valid,
  output logic [WEIGHT_BIT_WIDTH-1:0] meas_delay,
  output logic [WEIGHT_BIT_WIDTH-1:0] meas_width,
  output logic                        meas_trig_pol,
  output logic                        meas_timeout
);

  localparam int W = WEIGHT_BIT_WIDTH;
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_RESP  = 2'd1,
    MEAS_WIDTH = 2'd2,
    REPORT     = 2'd3
  } state_t;

  state_t state, state_next;

  // Synchronizer and edge-detect stages. Both inputs see identical latency,
  // so the pipeline delay cancels out of every measured interval.
  logic trig_s1, trig_s2, trig_d;
  logic out_s1, out_s2, out_d;

  logic trig_edge, out_fall, out_rise;

  // Cycle counter and internally held measurement pieces.
  logic [W-1:0] cnt;
  logic [W-1:0] delay_r;
  logic         pol_r;
  logic         cnt_sat;

  // Control strobes produced by the next-state logic.
  logic         do_start;     // new measurement: restart count, latch polarity
  logic         do_width;     // output fell: capture delay, restart count
  logic         do_commit;    // entering REPORT: publish meas_* together
  logic         do_timeout;   // commit is due to saturation
  logic [W-1:0] commit_delay;
  logic [W-1:0] commit_width;

  // Trigger synchronizer: idles low out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= trigger_in;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  // Timer-output synchronizer: idles high (inactive) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_s1 <= 1'b1;
      out_s2 <= 1'b1;
      out_d  <= 1'b1;
    end else begin
      out_s1 <= delay_out_n;
      out_s2 <= out_s1;
      out_d  <= out_s2;
    end
  end

  assign trig_edge = trig_s2 ^ trig_d;
  assign out_fall  = out_d & ~out_s2;
  assign out_rise  = ~out_d & out_s2;
  assign cnt_sat   = (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus the datapath strobes that go with each transition.
  // In WAIT_RESP an output edge outranks a simultaneous trigger edge, which
  // in turn outranks saturation.
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_width   = 1'b0;
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          state_next = WAIT_RESP;
          do_start   = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (out_fall) begin
          state_next = MEAS_WIDTH;
          do_width   = 1'b1;
        end else if (out_rise) begin
          state_next = REPORT;
          do_commit  = 1'b1;
        end else if (trig_edge) begin
          do_start   = 1'b1;
        end else if (cnt_sat) begin
          state_next = REPORT;
          do_commit  = 1'b1;
          do_timeout = 1'b1;
        end
      end
      MEAS_WIDTH: begin
        if (out_rise) begin
          state_next = REPORT;
          do_commit  = 1'b1;
        end else if (cnt_sat) begin
          state_next = REPORT;
          do_commit  = 1'b1;
          do_timeout = 1'b1;
        end
      end
      REPORT: begin
        if (trig_edge) begin
          state_next = WAIT_RESP;
          do_start   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    busy       = (state != IDLE);
    meas_valid = (state == REPORT);
  end

  // Values published on commit. From WAIT_RESP the delay is the live count and
  // the width is zero; from MEAS_WIDTH the delay was captured at the fall.
  always_comb begin
    commit_delay = delay_r;
    commit_width = cnt;
    if (state == WAIT_RESP) begin
      commit_delay = cnt;
      commit_width = '0;
    end
  end

  // Cycle counter. The register holds the count of the cycle it is read in:
  // the start cycle counts as 0, so the first following cycle reads 1 and the
  // value equals cycles elapsed since the start event. Saturates, never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (do_start || do_width) begin
      cnt <= CNT_ONE;
    end else if ((state == WAIT_RESP || state == MEAS_WIDTH) && !cnt_sat) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // In-flight measurement state: trigger polarity and the captured delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol_r   <= 1'b0;
      delay_r <= '0;
    end else begin
      if (do_start) pol_r   <= trig_s2;
      if (do_width) delay_r <= cnt;
    end
  end

  // Published results; they only change on the transition into REPORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_delay    <= '0;
      meas_width    <= '0;
      meas_trig_pol <= 1'b0;
      meas_timeout  <= 1'b0;
    end else if (do_commit) begin
      meas_delay    <= commit_delay;
      meas_width    <= commit_width;
      meas_trig_pol <= pol_r;
      meas_timeout  <= do_timeout;
    end
  end

endmodule

// File: tb/tb_delay_timer_meter.sv
// Directed bench for delay_timer_meter: an 8-bit instance for the main
// scenarios and a 4-bit instance for saturation behaviour.
module tb_delay_timer_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0, out_n = 1'b1;
  logic trig4 = 1'b0, out4_n = 1'b1;

  logic       busy, valid, pol, tmo;
  logic [7:0] dly, wid;
  logic       busy4, valid4, pol4, tmo4;
  logic [3:0] dly4, wid4;

  int n_run = 0;
  int n_fail = 0;

  // Pulse log for the 8-bit instance.
  int         vcnt = 0;
  logic [7:0] d_log [64];
  logic [7:0] w_log [64];
  logic       p_log [64];
  logic       t_log [64];

  always #5 clk = ~clk;

  delay_timer_meter #(.WEIGHT_BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .trigger_in(trig), .delay_out_n(out_n),
    .busy(busy), .meas_valid(valid), .meas_delay(dly), .meas_width(wid),
    .meas_trig_pol(pol), .meas_timeout(tmo)
  );

  delay_timer_meter #(.WEIGHT_BIT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .trigger_in(trig4), .delay_out_n(out4_n),
    .busy(busy4), .meas_valid(valid4), .meas_delay(dly4), .meas_width(wid4),
    .meas_trig_pol(pol4), .meas_timeout(tmo4)
  );

  // Record every meas_valid pulse of the 8-bit instance.
  always @(negedge clk) begin
    if (valid && vcnt < 64) begin
      d_log[vcnt] <= dly;
      w_log[vcnt] <= wid;
      p_log[vcnt] <= pol;
      t_log[vcnt] <= tmo;
    end
    if (valid) vcnt <= vcnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    tick(3);
    n_run++; if ({busy, valid, pol, tmo} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, valid, pol, tmo}); end
    n_run++; if ({dly, wid} !== 16'h0) begin n_fail++; $display("FAIL reset_meas got %h want 0000", {dly, wid}); end
    n_run++; if ({busy4, valid4, pol4, tmo4, dly4, wid4} !== 12'h0) begin n_fail++; $display("FAIL reset_w4 got %h want 000", {busy4, valid4, pol4, tmo4, dly4, wid4}); end
    rst = 1'b0;
    tick(3);
  endtask

  // Rise, fall 3 later, rise 10 after that.
  task automatic test_basic;
    int base = vcnt;
    trig = 1'b1; tick(3);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy got %b want 1", busy); end
    out_n = 1'b0; tick(10);
    out_n = 1'b1; tick(8);
    n_run++; if (vcnt - base !== 1) begin n_fail++; $display("FAIL t1_pulses got %0d want 1", vcnt - base); end
    n_run++; if (d_log[base] !== 8'd3) begin n_fail++; $display("FAIL t1_delay got %0d want 3", d_log[base]); end
    n_run++; if (w_log[base] !== 8'd10) begin n_fail++; $display("FAIL t1_width got %0d want 10", w_log[base]); end
    n_run++; if ({p_log[base], t_log[base]} !== 2'b10) begin n_fail++; $display("FAIL t1_pol_tmo got %b want 10", {p_log[base], t_log[base]}); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle got %b want 0", busy); end
    n_run++; if ({dly, wid} !== {8'd3, 8'd10}) begin n_fail++; $display("FAIL t1_held got %0d/%0d want 3/10", dly, wid); end
  endtask

  // Output fall in IDLE is ignored; then trigger fall, output rise 5 later.
  task automatic test_rise_only;
    int base = vcnt;
    out_n = 1'b0; tick(6);
    n_run++; if (busy !== 1'b0 || vcnt != base) begin n_fail++; $display("FAIL t2_idle_ignore got busy=%b pulses=%0d want 0/0", busy, vcnt - base); end
    trig = 1'b0; tick(5);
    out_n = 1'b1; tick(8);
    n_run++; if (vcnt - base !== 1) begin n_fail++; $display("FAIL t2_pulses got %0d want 1", vcnt - base); end
    n_run++; if ({d_log[base], w_log[base]} !== {8'd5, 8'd0}) begin n_fail++; $display("FAIL t2_meas got %0d/%0d want 5/0", d_log[base], w_log[base]); end
    n_run++; if ({p_log[base], t_log[base]} !== 2'b00) begin n_fail++; $display("FAIL t2_pol_tmo got %b want 00", {p_log[base], t_log[base]}); end
  endtask

  // Retrigger 4 cycles in; fall 6 after second edge, rise 2 later.
  task automatic test_retrigger;
    int base = vcnt;
    trig = 1'b1; tick(4);
    trig = 1'b0; tick(6);
    out_n = 1'b0; tick(2);
    out_n = 1'b1; tick(8);
    n_run++; if (vcnt - base !== 1) begin n_fail++; $display("FAIL t4_pulses got %0d want 1", vcnt - base); end
    n_run++; if ({d_log[base], w_log[base]} !== {8'd6, 8'd2}) begin n_fail++; $display("FAIL t4_meas got %0d/%0d want 6/2", d_log[base], w_log[base]); end
    n_run++; if (p_log[base] !== 1'b0) begin n_fail++; $display("FAIL t4_pol got %b want 0", p_log[base]); end
  endtask

  // Output fall coincides with a trigger edge: fall wins, trigger dropped.
  task automatic test_collision;
    int base = vcnt;
    trig = 1'b1; tick(3);
    trig = 1'b0; out_n = 1'b0; tick(4);
    out_n = 1'b1; tick(8);
    n_run++; if (vcnt - base !== 1) begin n_fail++; $display("FAIL t5_pulses got %0d want 1", vcnt - base); end
    n_run++; if ({d_log[base], w_log[base]} !== {8'd3, 8'd4}) begin n_fail++; $display("FAIL t5_meas got %0d/%0d want 3/4", d_log[base], w_log[base]); end
    n_run++; if (p_log[base] !== 1'b1) begin n_fail++; $display("FAIL t5_pol got %b want 1", p_log[base]); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_dropped got busy=%b want 0", busy); end
  endtask

  // Trigger edge lands in the REPORT cycle and starts the next measurement.
  task automatic test_back_to_back;
    int base = vcnt;
    trig = 1'b1; tick(3);
    out_n = 1'b0; tick(4);
    out_n = 1'b1; tick(1);
    trig = 1'b0; tick(4);
    out_n = 1'b0; tick(3);
    out_n = 1'b1; tick(8);
    n_run++; if (vcnt - base !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", vcnt - base); end
    n_run++; if ({d_log[base], w_log[base], 7'd0, p_log[base]} !== {8'd3, 8'd4, 8'd1}) begin n_fail++; $display("FAIL b2b_first got %0d/%0d/%b want 3/4/1", d_log[base], w_log[base], p_log[base]); end
    n_run++; if ({d_log[base+1], w_log[base+1], 7'd0, p_log[base+1]} !== {8'd4, 8'd3, 8'd0}) begin n_fail++; $display("FAIL b2b_second got %0d/%0d/%b want 4/3/0", d_log[base+1], w_log[base+1], p_log[base+1]); end
  endtask

  // Reset mid MEAS_WIDTH aborts silently; next measurement is normal.
  task automatic test_reset_abort;
    int base = vcnt;
    trig = 1'b1; tick(2);
    out_n = 1'b0; tick(4);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy got %b want 1", busy); end
    rst = 1'b1; #1;
    n_run++; if ({busy, valid, pol, tmo, dly, wid} !== 20'h0) begin n_fail++; $display("FAIL t6_async got %h want 00000", {busy, valid, pol, tmo, dly, wid}); end
    trig = 1'b0; out_n = 1'b1;
    tick(2);
    rst = 1'b0; tick(5);
    n_run++; if (vcnt != base || busy !== 1'b0) begin n_fail++; $display("FAIL t6_no_pulse got pulses=%0d busy=%b want 0/0", vcnt - base, busy); end
    trig = 1'b1; tick(7);
    out_n = 1'b0; tick(5);
    out_n = 1'b1; tick(8);
    n_run++; if (vcnt - base !== 1) begin n_fail++; $display("FAIL t6_pulses got %0d want 1", vcnt - base); end
    n_run++; if ({d_log[base], w_log[base], 7'd0, p_log[base]} !== {8'd7, 8'd5, 8'd1}) begin n_fail++; $display("FAIL t6_meas got %0d/%0d/%b want 7/5/1", d_log[base], w_log[base], p_log[base]); end
  endtask

  // W=4: no response at all -> delay saturates at 15 with timeout.
  task automatic test_delay_timeout;
    int lat = 0;
    trig4 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid4 === 1'b1) begin lat = i; break; end
    end
    n_run++; if (lat !== 18) begin n_fail++; $display("FAIL t3_latency got %0d want 18", lat); end
    n_run++; if ({dly4, wid4} !== {4'd15, 4'd0}) begin n_fail++; $display("FAIL t3_meas got %0d/%0d want 15/0", dly4, wid4); end
    n_run++; if ({pol4, tmo4} !== 2'b11) begin n_fail++; $display("FAIL t3_pol_tmo got %b want 11", {pol4, tmo4}); end
    tick(3);
    n_run++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL t3_idle got %b want 0", busy4); end
  endtask

  // W=4: width saturates, then a normal run clears the timeout flag.
  task automatic test_width_timeout;
    int seen = 0;
    trig4 = 1'b0; tick(2);
    out4_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid4 === 1'b1) begin seen = 1; break; end
    end
    n_run++; if (seen != 1) begin n_fail++; $display("FAIL tw_seen got %0d want 1", seen); end
    n_run++; if ({dly4, wid4, pol4, tmo4} !== {4'd2, 4'd15, 2'b01}) begin n_fail++; $display("FAIL tw_meas got %0d/%0d/%b%b want 2/15/01", dly4, wid4, pol4, tmo4); end
    tick(3);
    out4_n = 1'b1; tick(4);
    n_run++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL tw_idle got %b want 0", busy4); end
    trig4 = 1'b1; tick(2);
    out4_n = 1'b0; tick(3);
    out4_n = 1'b1;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid4 === 1'b1) begin seen = 1; break; end
    end
    n_run++; if (seen != 1) begin n_fail++; $display("FAIL tw2_seen got %0d want 1", seen); end
    n_run++; if ({dly4, wid4, pol4, tmo4} !== {4'd2, 4'd3, 2'b10}) begin n_fail++; $display("FAIL tw2_meas got %0d/%0d/%b%b want 2/3/10", dly4, wid4, pol4, tmo4); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rise_only;
    test_retrigger;
    test_collision;
    test_back_to_back;
    test_reset_abort;
    test_delay_timeout;
    test_width_timeout;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
